overture_pc_stack: RTL and testbench

OVERTURE_PC_STACK -- requirements
Module: overture_pc_stack

---
 rtl/overture_pkg.sv | 15 +
 rtl/overture_lifo.sv | 53 +++++
 rtl/overture_pc_stack.sv | 119 +++++++++++
 tb/tb_overture_pc_stack.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/overture_pkg.sv
// Shared types and default sizes for the program-counter / return-stack block.
// No logic here, so there is no latency.
// No flow control here; the sequencer's run input is its only stall.
package overture_pkg;

   localparam int OVERTURE_PC_WIDTH    = 8;
   localparam int OVERTURE_STACK_DEPTH = 4;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      FAULT  = 2'd2
   } pc_state_t;

endpackage

// File: rtl/overture_lifo.sv
// Return-address LIFO; top-of-stack is presented combinationally on pop_dat.
// Latency: push/pop take effect at the next clk edge; pop_dat reads 0 when empty.
// Backpressure: none; push when full and pop when empty are ignored, and the caller must check count.
module overture_lifo
   import overture_pkg::*;
#(
   parameter int WIDTH = OVERTURE_PC_WIDTH,
   parameter int DEPTH = OVERTURE_STACK_DEPTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             push_dat,
   output logic [WIDTH-1:0]             pop_dat,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] top_idx;
   logic             full;
   logic             empty;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign wr_idx  = IDX_W'(count);
   assign top_idx = IDX_W'(count - CNT_W'(1));
   // Entries above count are stale; mask the read so they never leak out.
   assign pop_dat = empty ? '0 : mem[top_idx];

   // Occupancy counter: the only state in the stack that needs a reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         count <= count - CNT_W'(1);
      end
   end

   // Storage write; contents are meaningless until pushed, so no reset.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_idx] <= push_dat;
      end
   end

endmodule

// File: rtl/overture_pc_stack.sv
// Program counter with halt/jump/call/ret; the return stack exists only when OVERTURE_PC_STACK_EN is defined.
// Latency: pc, sp and state update one clk after the request; halted/fault decode the registered state.
// Backpressure: run=0 freezes everything; HALTED and FAULT are sticky until reset.
module overture_pc_stack
   import overture_pkg::*;
#(
   parameter int WIDTH = OVERTURE_PC_WIDTH,
   parameter int DEPTH = OVERTURE_STACK_DEPTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         run,
   input  logic                         jump_en,
   input  logic [WIDTH-1:0]             jump_addr,
   input  logic                         call_en,
   input  logic                         ret_en,
   input  logic                         halt,
   output logic [WIDTH-1:0]             pc,
   output logic [$clog2(DEPTH+1)-1:0]   sp,
   output logic                         halted,
   output logic                         fault
);

   pc_state_t        state;
   pc_state_t        state_nxt;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] pc_inc;

   // Natural wrap at 2^WIDTH; also the return address a call pushes.
   assign pc_inc = pc + WIDTH'(1);

`ifdef OVERTURE_PC_STACK_EN
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] top_dat;

   overture_lifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .push_dat (pc_inc),
      .pop_dat  (top_dat),
      .count    (sp)
   );

   assign fault = (state == FAULT);

   // Request arbitration: halt > ret > call > jump > increment; stack misuse traps to FAULT.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      push      = 1'b0;
      pop       = 1'b0;
      if (state == RUN && run) begin
         if (halt) begin
            state_nxt = HALTED;
         end else if (ret_en) begin
            if (sp != '0) begin
               pc_nxt = top_dat;
               pop    = 1'b1;
            end else begin
               state_nxt = FAULT;
            end
         end else if (call_en) begin
            if (sp != ($clog2(DEPTH+1))'(DEPTH)) begin
               pc_nxt = jump_addr;
               push   = 1'b1;
            end else begin
               state_nxt = FAULT;
            end
         end else if (jump_en) begin
            pc_nxt = jump_addr;
         end else begin
            pc_nxt = pc_inc;
         end
      end
   end
`else
   // Without a stack, ret_en has no meaning and is deliberately dropped.
   logic unused_ret;
   assign unused_ret = ret_en;

   assign sp    = '0;
   assign fault = 1'b0;

   // Request arbitration: halt > call/jump (same slot) > increment.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      if (state == RUN && run) begin
         if (halt) begin
            state_nxt = HALTED;
         end else if (call_en || jump_en) begin
            pc_nxt = jump_addr;
         end else begin
            pc_nxt = pc_inc;
         end
      end
   end
`endif

   // State and pc registers; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         pc    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   assign halted = (state == HALTED);

endmodule

// File: tb/tb_overture_pc_stack.sv
// Scoreboard bench for overture_pc_stack (WIDTH=8, DEPTH=4), covering both build configurations.
// Expected results are queued when stimulus is driven and checked 1 ns after the following edge.
// Inputs change on the falling edge only.
module tb_overture_pc_stack;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic       jump_en;
   logic [7:0] jump_addr;
   logic       call_en;
   logic       ret_en;
   logic       halt;
   logic [7:0] pc;
   logic [2:0] sp;
   logic       halted;
   logic       fault;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string      tag;
      logic [7:0] pc;
      logic [2:0] sp;
      logic       halted;
      logic       fault;
   } exp_t;

   exp_t exp_q[$];

   overture_pc_stack #(.WIDTH(8), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .jump_en   (jump_en),
      .jump_addr (jump_addr),
      .call_en   (call_en),
      .ret_en    (ret_en),
      .halt      (halt),
      .pc        (pc),
      .sp        (sp),
      .halted    (halted),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus and queue what the outputs must show after the edge.
   task automatic step(input string tag, input logic r, input logic rs,
                       input logic je, input logic ce, input logic re, input logic h,
                       input logic [7:0] ja, input logic [7:0] epc, input logic [2:0] esp,
                       input logic eh, input logic ef);
      exp_t e;
      @(negedge clk);
      run       = r;
      reset     = rs;
      jump_en   = je;
      call_en   = ce;
      ret_en    = re;
      halt      = h;
      jump_addr = ja;
      e.tag = tag; e.pc = epc; e.sp = esp; e.halted = eh; e.fault = ef;
      exp_q.push_back(e);
   endtask

   // Output monitor: pops one expectation per edge once stimulus has started.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk({e.tag, ".pc"},     32'(pc),     32'(e.pc));
         chk({e.tag, ".sp"},     32'(sp),     32'(e.sp));
         chk({e.tag, ".halted"}, 32'(halted), 32'(e.halted));
         chk({e.tag, ".fault"},  32'(fault),  32'(e.fault));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] sp_h;
      reset = 1'b1; run = 1'b0; jump_en = 1'b0; call_en = 1'b0;
      ret_en = 1'b0; halt = 1'b0; jump_addr = 8'h00;

      //   tag          run rst je ce re h  ja     pc     sp hl ft
      step("rst",        0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      step("inc1",       1, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0);
      step("inc2",       1, 0, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0);
      step("inc3",       1, 0, 0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0);
      step("run0",       0, 0, 0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0);
      step("rst_mid",    1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      step("rst_call",   1, 1, 0, 1, 0, 0, 8'h40, 8'h00, 0, 0, 0);
      step("jmp_ff",     1, 0, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 0);
      step("wrap",       1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         step("run0_hold", 0, 0, 1, 1, 1, 1, 8'h99, 8'h00, 0, 0, 0);
      step("jmp_10",     1, 0, 1, 0, 0, 0, 8'h10, 8'h10, 0, 0, 0);

`ifdef OVERTURE_PC_STACK_EN
      step("call_40",    1, 0, 0, 1, 0, 0, 8'h40, 8'h40, 1, 0, 0);
      step("ret_11",     1, 0, 0, 0, 1, 0, 8'h00, 8'h11, 0, 0, 0);
      step("call_50",    1, 0, 0, 1, 0, 0, 8'h50, 8'h50, 1, 0, 0);
      step("call_60",    1, 0, 0, 1, 0, 0, 8'h60, 8'h60, 2, 0, 0);
      step("ret_pri",    1, 0, 1, 1, 1, 0, 8'h99, 8'h51, 1, 0, 0);
      step("ret_last",   1, 0, 0, 0, 1, 0, 8'h00, 8'h12, 0, 0, 0);
      step("rst_a",      1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      step("nest1",      1, 0, 0, 1, 0, 0, 8'h50, 8'h50, 1, 0, 0);
      step("nest2",      1, 0, 0, 1, 0, 0, 8'h60, 8'h60, 2, 0, 0);
      step("nest3",      1, 0, 0, 1, 0, 0, 8'h70, 8'h70, 3, 0, 0);
      step("nest4",      1, 0, 0, 1, 0, 0, 8'h80, 8'h80, 4, 0, 0);
      step("call_ovf",   1, 0, 0, 1, 0, 0, 8'h90, 8'h80, 4, 0, 1);
      step("fault_jmp",  1, 0, 1, 0, 0, 0, 8'h05, 8'h80, 4, 0, 1);
      step("fault_ret",  1, 0, 0, 0, 1, 0, 8'h00, 8'h80, 4, 0, 1);
      step("rst_fault",  0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      step("ret_unf",    1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1);
      step("rst_b",      1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      step("call_20",    1, 0, 0, 1, 0, 0, 8'h20, 8'h20, 1, 0, 0);
      sp_h = 3'd1;
`else
      step("call_40",    1, 0, 0, 1, 0, 0, 8'h40, 8'h40, 0, 0, 0);
      step("ret_ign",    1, 0, 0, 0, 1, 0, 8'h00, 8'h41, 0, 0, 0);
      step("call_33",    1, 0, 0, 1, 0, 0, 8'h33, 8'h33, 0, 0, 0);
      step("ret_inc",    1, 0, 0, 0, 1, 0, 8'h00, 8'h34, 0, 0, 0);
      step("ret_jmp",    1, 0, 1, 0, 1, 0, 8'h55, 8'h55, 0, 0, 0);
      step("call_jmp",   1, 0, 1, 1, 0, 0, 8'h66, 8'h66, 0, 0, 0);
      step("jmp_20",     1, 0, 1, 0, 0, 0, 8'h20, 8'h20, 0, 0, 0);
      sp_h = 3'd0;
`endif

      step("halt_run0",  0, 0, 0, 0, 0, 1, 8'h00, 8'h20, sp_h, 0, 0);
      step("halt_call",  1, 0, 0, 1, 0, 1, 8'h77, 8'h20, sp_h, 1, 0);
      step("halted_jmp", 1, 0, 1, 0, 0, 0, 8'h44, 8'h20, sp_h, 1, 0);
      step("halted_ret", 1, 0, 0, 0, 1, 0, 8'h00, 8'h20, sp_h, 1, 0);
      step("halted_inc", 1, 0, 0, 0, 0, 0, 8'h00, 8'h20, sp_h, 1, 0);
      step("rst_halt",   0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      step("post_rst",   1, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0);

      @(negedge clk);
      run = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
